pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the MIPS core.
//  Forms J/JAL targets as {pc_plus4[31:28], target, 2'b00}, JR targets from a register, and branch targets.
//  Issues fetch requests to instruction memory and squashes wrong-path slots after a redirect.
//  Sits between decode/execute redirect logic and the instruction-memory port.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset
//  FLUSH_SLOTS  2              squash cycles after a redirect (1..3)
//  EXC_VECTOR   32'h8000_0180  exception entry PC (used only with PC_SEQ_EXC_EN)
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  stall         in   1   hold PC; no new fetch issued
//  jump_en       in   1   J/JAL redirect request
//  jump_target   in   26  instruction target field
//  jr_en         in   1   JR/JALR redirect request
//  jr_addr       in   32  register target
//  branch_en     in   1   taken-branch redirect request
//  branch_imm    in   16  branch offset in words
//  redir_pc      in   32  PC of the redirecting instruction
//  imem_ack      in   1   imem has accepted and returned the outstanding fetch
//  imem_req      out  1   fetch request; held high until imem_ack
//  imem_addr     out  32  fetch address (== pc_out)
//  pc_out        out  32  current PC
//  pc_plus4      out  32  pc_out + 4 (link value)
//  fetch_valid   out  1   1-cycle pulse: returned instruction is on the correct path
//  flush         out  1   squash downstream slots
//  exc_pc        out  32  saved EPC (PC_SEQ_EXC_EN only)
// BEHAVIOUR
//  Reset: pc_out=RESET_PC, imem_req=0, fetch_valid=0, flush=0, exc_pc=0, state=BOOT.
//  FSM:
//   BOOT  -> FETCH after 1 cycle.
//   FETCH: if !stall, imem_req=1 -> WAIT.
//   WAIT:  imem_req held high and imem_addr stable until imem_ack.
//          On ack: fetch_valid=1 unless a redirect is pending/flushing;
//          pc <= pc+4 unless a redirect was latched; -> FETCH, or -> FLUSH if flush_cnt!=0.
//   FLUSH: flush=1, flush_cnt decrements; -> FETCH at 0.
//  Redirect priority: exception > jr_en > jump_en > branch_en; lower-priority requests in the same cycle are dropped.
//  Targets (all 32-bit, wrap mod 2^32):
//   jump   = {redir_pc+4}[31:28] ++ jump_target ++ 2'b00
//   jr     = jr_addr (low 2 bits forced to 0)
//   branch = redir_pc + 4 + (sign_ext(branch_imm) << 2)
//  Redirect latched in 1 cycle; new address on imem_addr the next FETCH cycle; flush_cnt loaded with FLUSH_SLOTS.
//  Redirect in WAIT: outstanding fetch completes, its data is dropped (fetch_valid=0), then the new PC is used.
//  A second redirect while FLUSH overrides the target and reloads flush_cnt.
//  stall: blocks FETCH->WAIT only; an outstanding req is never withdrawn. A redirect is still latched during stall.
//  Reset asserted mid-WAIT: request dropped immediately; no ack is expected afterwards.
// CONFIGURATION
//  PC_SEQ_EXC_EN defined: adds input exc_req (1 bit, top priority).
//   On exc_req: exc_pc <= pc_out, PC <= EXC_VECTOR, flush for FLUSH_SLOTS cycles.
//  Undefined: no exc_req port, exc_pc tied to 0, no exception priority level.
// STRUCTURE
//  Shared pkg: state encodings (BOOT/FETCH/WAIT/FLUSH), redirect-source enum, WORD_BYTES=4.
//  Submodule pc_target_gen: combinational jump/jr/branch target and priority mux.
//  FSM, PC register and flush counter stay in the top module.
// TESTING
//  Reset release, ack on every cycle -> imem_addr 0x0, 0x4, 0x8; fetch_valid pulses on each ack.
//  Jump: redir_pc=0x1000_0010, target=26'h0000040 -> next imem_addr 0x1000_0100; flush high 2 cycles.
//  Branch: redir_pc=0x20, imm=16'hFFFE -> 0x1C. Same cycle jr_en with jr_addr=0x400 -> 0x400 wins.
//  Redirect during WAIT with ack delayed 3 cycles -> old data dropped (fetch_valid=0), then new PC fetched.
//  stall held 4 cycles in FETCH -> imem_req=0, pc_out constant; jump during stall is applied after release.
//  PC_SEQ_EXC_EN: exc_req at pc=0x40 -> exc_pc=0x40, next imem_addr=0x8000_0180.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types for the PC fetch sequencer.
// FSM states, redirect sources and word-size helpers.
package pc_fetch_sequencer_pkg;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_WAIT,
    ST_FLUSH
  } state_e;

  typedef enum logic [2:0] {
    RS_NONE,
    RS_EXC,
    RS_JR,
    RS_JUMP,
    RS_BRANCH
  } redir_src_e;

  function automatic logic [31:0] sext_words(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch port of the PC sequencer.
// Request is held with a stable address until acknowledged.
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );
endinterface

// File: rtl/pc_fetch_sequencer_target_gen.sv
// Redirect target formation and priority selection.
// Exception inputs exist only when PC_SEQ_EXC_EN is defined.
module pc_target_gen
  import pc_fetch_sequencer_pkg::*;
(
`ifdef PC_SEQ_EXC_EN
  input  logic        exc_i,
  input  logic [31:0] exc_vec_i,
  output logic        exc_o,
`endif
  input  logic        jr_en_i,
  input  logic [31:0] jr_addr_i,
  input  logic        jump_en_i,
  input  logic [25:0] jump_target_i,
  input  logic        branch_en_i,
  input  logic [15:0] branch_imm_i,
  input  logic [31:0] redir_pc_i,
  output logic        valid_o,
  output logic [31:0] target_o
);

  logic [31:0] rp4;
  logic [31:0] jmp_t;
  logic [31:0] jr_t;
  logic [31:0] br_t;
  redir_src_e  src;

  assign rp4   = redir_pc_i + WORD_BYTES;
  assign jmp_t = {rp4[31:28], jump_target_i, 2'b00};
  assign jr_t  = jr_addr_i & ~32'h3;
  assign br_t  = rp4 + sext_words(branch_imm_i);

  // Later assignments win: lowest priority first.
  always_comb begin
    src = RS_NONE;
    if (branch_en_i) src = RS_BRANCH;
    if (jump_en_i)   src = RS_JUMP;
    if (jr_en_i)     src = RS_JR;
`ifdef PC_SEQ_EXC_EN
    if (exc_i)       src = RS_EXC;
`endif
  end

  // Target for the winning source.
  always_comb begin
    target_o = '0;
    unique case (src)
`ifdef PC_SEQ_EXC_EN
      RS_EXC:    target_o = exc_vec_i;
`endif
      RS_JR:     target_o = jr_t;
      RS_JUMP:   target_o = jmp_t;
      RS_BRANCH: target_o = br_t;
      default:   target_o = '0;
    endcase
  end

  assign valid_o = (src != RS_NONE);
`ifdef PC_SEQ_EXC_EN
  assign exc_o = (src == RS_EXC);
`endif

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction fetch sequencer.
// Define PC_SEQ_EXC_EN to add exc_req, EXC_VECTOR and exc_pc capture.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned FLUSH_SLOTS = 2
`ifdef PC_SEQ_EXC_EN
  ,
  parameter logic [31:0] EXC_VECTOR  = 32'h8000_0180
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
`ifdef PC_SEQ_EXC_EN
  input  logic        exc_req,
`endif
  input  logic        jump_en,
  input  logic [25:0] jump_target,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  input  logic        branch_en,
  input  logic [15:0] branch_imm,
  input  logic [31:0] redir_pc,
  pc_fetch_sequencer_if.master imem,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic [31:0] exc_pc
);

  localparam logic [1:0] FS = 2'(FLUSH_SLOTS);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic        pend_q;
  logic [1:0]  cnt_q;
  logic        req_q;
  logic        valid_q;
  logic        flush_q;

  logic        new_v;
  logic [31:0] new_t;
  logic        have_d;
  logic [31:0] sel_d;
`ifdef PC_SEQ_EXC_EN
  logic        new_exc;
`endif

  pc_target_gen u_tgt (
`ifdef PC_SEQ_EXC_EN
    .exc_i         (exc_req),
    .exc_vec_i     (EXC_VECTOR),
    .exc_o         (new_exc),
`endif
    .jr_en_i       (jr_en),
    .jr_addr_i     (jr_addr),
    .jump_en_i     (jump_en),
    .jump_target_i (jump_target),
    .branch_en_i   (branch_en),
    .branch_imm_i  (branch_imm),
    .redir_pc_i    (redir_pc),
    .valid_o       (new_v),
    .target_o      (new_t)
  );

  // A fresh redirect overrides one already latched.
  assign have_d = new_v | pend_q;
  assign sel_d  = new_v ? new_t : tgt_q;

  // Fetch FSM, PC register and flush counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_BOOT: begin
          if (have_d) begin
            pend_q <= 1'b1;
            tgt_q  <= sel_d;
          end
          state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (have_d && !stall) begin
            pc_q    <= sel_d;
            pend_q  <= 1'b0;
            cnt_q   <= FS;
            flush_q <= 1'b1;
            state_q <= ST_FLUSH;
          end else if (have_d) begin
            pend_q <= 1'b1;
            tgt_q  <= sel_d;
          end else if (!stall) begin
            req_q   <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem.imem_ack) begin
            req_q <= 1'b0;
            if (have_d) begin
              pc_q    <= sel_d;
              pend_q  <= 1'b0;
              cnt_q   <= FS;
              flush_q <= 1'b1;
              state_q <= ST_FLUSH;
            end else begin
              valid_q <= 1'b1;
              pc_q    <= pc_q + WORD_BYTES;
              state_q <= ST_FETCH;
            end
          end else if (new_v) begin
            pend_q <= 1'b1;
            tgt_q  <= new_t;
          end
        end
        ST_FLUSH: begin
          if (new_v) begin
            pc_q  <= new_t;
            cnt_q <= FS;
          end else if (cnt_q <= 2'd1) begin
            cnt_q   <= '0;
            flush_q <= 1'b0;
            state_q <= ST_FETCH;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

`ifdef PC_SEQ_EXC_EN
  logic [31:0] epc_q;

  // Save the interrupted PC on exception entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q <= '0;
    end else if (new_exc) begin
      epc_q <= pc_q;
    end
  end

  assign exc_pc = epc_q;
`else
  assign exc_pc = '0;
`endif

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc_out         = pc_q;
  assign pc_plus4       = pc_q + WORD_BYTES;
  assign fetch_valid    = valid_q;
  assign flush          = flush_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer.
// Exception scenario is included when PC_SEQ_EXC_EN is defined.
module tb_pc_fetch_sequencer;

`ifdef PC_SEQ_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        exc_req = 1'b0;
  logic        jump_en = 1'b0;
  logic [25:0] jump_target = '0;
  logic        jr_en = 1'b0;
  logic [31:0] jr_addr = '0;
  logic        branch_en = 1'b0;
  logic [15:0] branch_imm = '0;
  logic [31:0] redir_pc = '0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
  logic [31:0] exc_pc;

  pc_fetch_sequencer_if imem();

  always #5 clk = ~clk;

  pc_fetch_sequencer #(
    .RESET_PC    (32'h0),
    .FLUSH_SLOTS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
`ifdef PC_SEQ_EXC_EN
    .exc_req     (exc_req),
`endif
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .jr_en       (jr_en),
    .jr_addr     (jr_addr),
    .branch_en   (branch_en),
    .branch_imm  (branch_imm),
    .redir_pc    (redir_pc),
    .imem        (imem),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .exc_pc      (exc_pc)
  );

  typedef struct {
    logic [31:0] addr;
    bit          vld;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // reference model: next fetch address and the outstanding fetch
  logic [31:0] na = 32'h0;
  bit          in_flight = 1'b0;
  logic [31:0] fl_addr = '0;
  bit          fl_sq = 1'b0;
  int          exp_valid_n = 0;
  int          vcount = 0;

  bit          s_req;
  bit          s_start;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_pc4;
  int          flush_seen = 0;
  int          valid_seen = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // en: [3]=exc [2]=jr [1]=jump [0]=branch
  task automatic step(input bit st, input logic [3:0] en,
                      input logic [31:0] rpc, input logic [25:0] jt,
                      input logic [31:0] ja, input logic [15:0] bi,
                      input bit ack_ok);
    logic [31:0] t;
    bit redir;
    int off;
    @(negedge clk);
    s_req  = imem.imem_req;
    s_addr = imem.imem_addr;
    s_pc   = pc_out;
    s_pc4  = pc_plus4;
    if (flush) flush_seen++;
    if (fetch_valid) valid_seen++;
    stall         = st;
    exc_req       = en[3];
    jr_en         = en[2];
    jump_en       = en[1];
    branch_en     = en[0];
    redir_pc      = rpc;
    jump_target   = jt;
    jr_addr       = ja;
    branch_imm    = bi;
    imem.imem_ack = ack_ok & s_req;
    s_start = s_req && !in_flight;
    if (s_start) begin
      in_flight = 1'b1;
      fl_addr   = na;
      fl_sq     = 1'b0;
    end
    off = $signed(bi);
    redir = 1'b1;
    if (en[3] && EXC_ON) t = 32'h8000_0180;
    else if (en[2]) t = ja & 32'hFFFF_FFFC;
    else if (en[1]) t = ((rpc + 32'd4) & 32'hF000_0000) | (32'(jt) << 2);
    else if (en[0]) t = rpc + 32'd4 + off * 4;
    else begin
      t = '0;
      redir = 1'b0;
    end
    if (redir) begin
      if (in_flight) fl_sq = 1'b1;
      na = t;
    end
    if (s_req && ack_ok) begin
      sb.push_back('{addr: fl_addr, vld: !fl_sq});
      if (!fl_sq) begin
        na = fl_addr + 32'd4;
        exp_valid_n++;
      end
      in_flight = 1'b0;
    end
  endtask

  task automatic idle(input bit ack_ok);
    step(1'b0, 4'd0, '0, '0, '0, '0, ack_ok);
  endtask

  task automatic wait_req(input bit ack_ok, input logic [31:0] exp,
                          input string name);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      idle(ack_ok);
      got = s_start;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no_req required=%h", name, exp);
    end else begin
      chk(name, s_addr, exp);
    end
  endtask

  // monitor: every completed fetch is compared with the scoreboard
  initial begin
    logic [31:0] a;
    logic        v;
    exp_t        e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && imem.imem_req && imem.imem_ack) begin
        a = imem.imem_addr;
        @(posedge clk);
        #1;
        v = fetch_valid;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty actual=%h required=none", a);
        end else begin
          e = sb.pop_front();
          chk("sb_addr", a, e.addr);
          chk("sb_valid", 32'(v), 32'(e.vld));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && fetch_valid) vcount++;
    end
  end

  initial begin
    logic [3:0] en;
    imem.imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", 32'(imem.imem_req), 32'h0);
    chk("rst_valid", 32'(fetch_valid), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_exc_pc", exc_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    wait_req(1'b1, 32'h0, "seq0");
    wait_req(1'b1, 32'h4, "seq4");
    wait_req(1'b1, 32'h8, "seq8");

    flush_seen = 0;
    step(1'b0, 4'b0010, 32'h1000_0010, 26'h0000040, '0, '0, 1'b1);
    wait_req(1'b1, 32'h1000_0100, "jump");
    chk("jump_flush_cycles", 32'(flush_seen), 32'd2);
    chk("pc_plus4", s_pc4, 32'h1000_0104);

    step(1'b0, 4'b0001, 32'h20, '0, '0, 16'hFFFE, 1'b1);
    wait_req(1'b1, 32'h1C, "branch");
    step(1'b0, 4'b0101, 32'h20, '0, 32'h400, 16'hFFFE, 1'b1);
    wait_req(1'b1, 32'h400, "jr_over_branch");

    wait_req(1'b0, 32'h404, "wait_pre");
    valid_seen = 0;
    step(1'b0, 4'b0100, '0, '0, 32'h2000, '0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    wait_req(1'b1, 32'h2000, "wait_redir");
    chk("wait_drop", 32'(valid_seen), 32'd0);

    for (int i = 0; i < 4; i++) begin
      en = (i == 1) ? 4'b0010 : 4'b0000;
      step(1'b1, en, 32'h3000_0000, 26'h123, '0, '0, 1'b1);
      chk("stall_req", 32'(s_req), 32'h0);
      chk("stall_pc", s_pc, 32'h2004);
    end
    wait_req(1'b1, 32'h3000_048C, "stall_jump");

`ifdef PC_SEQ_EXC_EN
    step(1'b0, 4'b0100, '0, '0, 32'h40, '0, 1'b1);
    wait_req(1'b0, 32'h40, "exc_pre");
    step(1'b0, 4'b1000, '0, '0, '0, '0, 1'b0);
    idle(1'b1);
    wait_req(1'b1, 32'h8000_0180, "exc_vec");
    chk("exc_pc", exc_pc, 32'h40);
`endif

    repeat (3000) begin
      en = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      step($urandom_range(0, 4) == 0, en, $urandom, 26'($urandom),
           $urandom, 16'($urandom), $urandom_range(0, 1) == 1);
    end

    repeat (40) idle(1'b1);
    repeat (4) step(1'b1, 4'd0, '0, '0, '0, '0, 1'b1);
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("valid_count", 32'(vcount), 32'(exp_valid_n));

    wait_req(1'b0, na, "pre_reset");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_req", 32'(imem.imem_req), 32'h0);
    chk("rst_wait_pc", pc_out, 32'h0);
    in_flight = 1'b0;
    na = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_req(1'b1, 32'h0, "post_reset");
    repeat (4) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
